// File: rtl/alu_exec_stage.sv
// Execute stage behind the register file: single-cycle logic/arith ops and bit-serial shifts, valid/ready on both sides.
// Optional `define ALU_EXEC_SRA_EN turns op 000 into an iterative SRA; without it op 000 is MOV.
module alu_exec_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic [ADDR_W-1:0] wr_addr
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [4:0]          cnt_q, cnt_d;
`ifdef ALU_EXEC_SRA_EN
  logic                sra_q, sra_d;
`endif

  logic [DATA_W:0]     sum, diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v, is_shift;
  logic [4:0]          shamt;
  logic [DATA_W-1:0]   shift_res;
  logic                shift_c;
  logic                accept;

  assign shamt = b[4:0];

  // Single-cycle datapath; for shifts it just forwards a (the b[4:0]==0 result).
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    alu_res  = a;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = ~diff[DATA_W];
        alu_v   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  is_shift = 1'b1;
      default: begin
`ifdef ALU_EXEC_SRA_EN
        is_shift = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    shift_res = {result_q[DATA_W-2:0], 1'b0};
    shift_c   = result_q[DATA_W-1];
`ifdef ALU_EXEC_SRA_EN
    if (sra_q) begin
      shift_res = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
      shift_c   = result_q[0];
    end
`endif
  end

  // DONE with out_ready frees the stage in the same cycle so single-cycle ops stream back-to-back.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
`ifdef ALU_EXEC_SRA_EN
    sra_d     = sra_q;
`endif
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
    accept = in_valid & in_ready;

    if (state_q == SHIFT) begin
      result_d = shift_res;
      flags_d  = {shift_res[DATA_W-1], (shift_res == '0), shift_c, 1'b0};
      cnt_d    = cnt_q - 5'd1;
      if (cnt_q == 5'd1) state_d = DONE;
    end else if (accept) begin
      result_d  = alu_res;
      wr_addr_d = rd_addr;
      flags_d   = {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
      cnt_d     = shamt;
`ifdef ALU_EXEC_SRA_EN
      sra_d     = (op == 3'b000);
`endif
      state_d   = (is_shift && (shamt != 5'd0)) ? SHIFT : DONE;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      flags_q   <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
`ifdef ALU_EXEC_SRA_EN
      sra_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
`ifdef ALU_EXEC_SRA_EN
      sra_q     <= sra_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; expected values are hand-computed constants.
// Honours ALU_EXEC_SRA_EN for the op 000 vector.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [4:0]  wr_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .rd_addr  (rd_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .wr_addr  (wr_addr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one bundle, waits (bounded) for in_ready, returns 1 time unit after the accept edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                               input logic [4:0] rd);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; b = bv; rd_addr = rd;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom; rd_addr = 5'($urandom);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  // Counts latency (cycle 1 = cycle after accept) and busy cycles, then checks the bundle and consumes it.
  task automatic expectResult(input string tag, input int lat, input int busy,
                              input logic [31:0] res, input logic [3:0] fl, input logic [4:0] wa);
    int cyc;
    int busy_cnt;
    cyc = 1;
    busy_cnt = 0;
    while (!out_valid && cyc < 40) begin
      if (!in_ready) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_valid"},   {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_latency"}, cyc, lat);
    checkOutput({tag, "_busy"},    busy_cnt, busy);
    checkOutput({tag, "_result"},  result, res);
    checkOutput({tag, "_flags"},   {28'd0, flags}, {28'd0, fl});
    checkOutput({tag, "_wr_addr"}, {27'd0, wr_addr}, {27'd0, wa});
    consume();
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0; rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result",    result, 32'd0);
    checkOutput("rst_flags",     {28'd0, flags}, 32'd0);
    checkOutput("rst_wr_addr",   {27'd0, wr_addr}, 32'd0);
    checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // flags = {N,Z,C,V}
    applyStimulus(3'b001, 32'hFFFF000F, 32'h00010000, 5'd3);
    expectResult("add_carry", 1, 0, 32'h0000000F, 4'b0010, 5'd3);
    applyStimulus(3'b001, 32'h7FFFFFFF, 32'h00000001, 5'd1);
    expectResult("add_ovf", 1, 0, 32'h80000000, 4'b1001, 5'd1);
    applyStimulus(3'b010, 32'h80000000, 32'h00000001, 5'd7);
    expectResult("sub_ovf", 1, 0, 32'h7FFFFFFF, 4'b0011, 5'd7);
    applyStimulus(3'b010, 32'h00000005, 32'h00000005, 5'd8);
    expectResult("sub_zero", 1, 0, 32'h00000000, 4'b0110, 5'd8);
    applyStimulus(3'b010, 32'h00000003, 32'h00000005, 5'd9);
    expectResult("sub_borrow", 1, 0, 32'hFFFFFFFE, 4'b1000, 5'd9);
    applyStimulus(3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd10);
    expectResult("and", 1, 0, 32'hF000F000, 4'b1000, 5'd10);
    applyStimulus(3'b100, 32'h0000000F, 32'h000000F0, 5'd11);
    expectResult("or", 1, 0, 32'h000000FF, 4'b0000, 5'd11);
    applyStimulus(3'b101, 32'hAAAAAAAA, 32'hAAAAAAAA, 5'd12);
    expectResult("xor", 1, 0, 32'h00000000, 4'b0100, 5'd12);
    applyStimulus(3'b110, 32'hFFFFFFFF, 32'h00000001, 5'd13);
    expectResult("slt_true", 1, 0, 32'h00000001, 4'b0000, 5'd13);
    applyStimulus(3'b110, 32'h00000005, 32'hFFFFFFFD, 5'd14);
    expectResult("slt_false", 1, 0, 32'h00000000, 4'b0100, 5'd14);

    applyStimulus(3'b111, 32'h0000FFF0, 32'h00000004, 5'd15);
    expectResult("sll4", 5, 4, 32'h000FFF00, 4'b0000, 5'd15);
    applyStimulus(3'b111, 32'hC0000001, 32'h00000002, 5'd16);
    expectResult("sll2_carry", 3, 2, 32'h00000004, 4'b0010, 5'd16);
    applyStimulus(3'b111, 32'h12345678, 32'h00000020, 5'd17);
    expectResult("sll0", 1, 0, 32'h12345678, 4'b0000, 5'd17);
    applyStimulus(3'b111, 32'h00000003, 32'h0000001F, 5'd18);
    expectResult("sll31", 32, 31, 32'h80000000, 4'b1010, 5'd18);

    applyStimulus(3'b000, 32'h80000010, 32'h00000004, 5'd19);
`ifdef ALU_EXEC_SRA_EN
    expectResult("sra4", 5, 4, 32'hF8000001, 4'b1000, 5'd19);
`else
    expectResult("mov", 1, 0, 32'h80000010, 4'b1000, 5'd19);
`endif

    // Back-pressure: result must hold while a new bundle waits, then stream in on release.
    applyStimulus(3'b001, 32'h00000001, 32'h00000002, 5'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'b001; a = 32'd10; b = 32'd20; rd_addr = 5'd5;
      #1;
      checkOutput("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_result",    result, 32'd3);
      checkOutput("bp_wr_addr",   {27'd0, wr_addr}, 32'd4);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("b2b_result",    result, 32'd30);
    checkOutput("b2b_wr_addr",   {27'd0, wr_addr}, 32'd5);
    consume();

    // Reset two cycles into a long shift abandons it.
    applyStimulus(3'b111, 32'hFFFFFFFF, 32'h0000001F, 5'd20);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_result",    result, 32'd0);
    checkOutput("mid_rst_flags",     {28'd0, flags}, 32'd0);
    checkOutput("mid_rst_in_ready",  {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    seen_valid = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("post_rst_no_valid", {31'd0, seen_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
